// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  // Operation encodings as issued by the main decoder
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    RUN   = 2'b10,
    FIXUP = 2'b11
  } mdu_state_e;

  // Divide ops have the high encoding bit set
  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops have the low encoding bit clear
  function automatic logic mdu_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// One multiplier/quotient bit is produced per RUN cycle; sign handling is
// done on magnitudes, with negation applied as the result is written.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             div_zero;
  logic             sign_res;
  logic             sign_rem;
  logic [WIDTH-1:0] m_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;   // product high half or partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier/product low half or dividend/quotient
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // Operand magnitudes for signed ops; MIN_INT wraps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1)
  always_comb begin
    a_abs = a_q;
    b_abs = b_q;
    if (mdu_is_signed(op_q) && a_q[WIDTH-1]) a_abs = WIDTH'(-a_q);
    if (mdu_is_signed(op_q) && b_q[WIDTH-1]) b_abs = WIDTH'(-b_q);
  end

  // One shift-add or restoring-divide iteration
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (mdu_is_div(op_q)) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fixup on the final iteration's result, written to HI/LO on exit from RUN
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = sign_res ? (2*WIDTH)'(-prod) : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (mdu_is_div(op_q)) begin
      if (div_zero) begin
        fix_lo = '1;
        fix_hi = a_q;
      end else begin
        fix_lo = sign_res ? WIDTH'(-step_lo) : step_lo;
        fix_hi = sign_rem ? WIDTH'(-step_hi) : step_hi;
      end
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      div_zero <= 1'b0;
      sign_res <= 1'b0;
      sign_rem <= 1'b0;
      m_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // FIXUP is the done cycle; busy is already low, so it accepts work like IDLE
        IDLE, FIXUP: begin
          state <= IDLE;
          if (start) begin
            op_q     <= op;
            a_q      <= operand_a;
            b_q      <= operand_b;
            div_zero <= (operand_b == '0);
            busy     <= 1'b1;
            state    <= SETUP;
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        SETUP: begin
          sign_res <= mdu_is_signed(op_q) & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_rem <= mdu_is_signed(op_q) & a_q[WIDTH-1];
          m_q      <= mdu_is_div(op_q) ? b_abs : a_abs;
          acc_lo   <= mdu_is_div(op_q) ? a_abs : b_abs;
          acc_hi   <= '0;
          cnt      <= '0;
          state    <= RUN;
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIXUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned W = 32;
  localparam int unsigned LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic
  function automatic void model(input logic [1:0] mop, input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, up;
    logic [63:0] tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    eh = '0;
    el = '0;
    case (mop)
      2'b00: begin up = 64'(sa * sb); eh = up[63:32]; el = up[31:0]; end
      2'b01: begin up = ua * ub;      eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (b == 0) begin
          eh = a;
          el = '1;
        end else if (mop == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          tq = 64'(sq);
          tr = 64'(sr);
          el = tq[31:0];
          eh = tr[31:0];
        end else begin
          tq = ua / ub;
          tr = ua % ub;
          el = tq[31:0];
          eh = tr[31:0];
        end
      end
    endcase
  endfunction

  // Present a start for one edge (edge 0) and confirm busy rises
  task automatic launch(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op = mop;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    check("busy_rise", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges until done, bounded; busy must stay high until then
  task automatic wait_done(input int from_edge, output int edges);
    logic gap;
    gap = 1'b0;
    edges = from_edge;
    forever begin
      @(posedge clk);
      edges++;
      #1;
      if (done) break;
      if (!busy) gap = 1'b1;
      if (edges >= 200) break;
    end
    check("busy_hold", 64'(gap), 64'd0);
    check("latency", 64'(edges), 64'(LAT));
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic run_check(input string tag, input logic [1:0] mop,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    launch(mop, a, b);
    wait_done(0, n);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int extra;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb, eh, el;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed arithmetic corners
    run_check("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_check("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_check("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("divu_zero", 2'b11, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
    run_check("div_zero",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_check("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Start while busy is ignored
    launch(2'b01, 32'd6, 32'd7);
    n = 0;
    repeat (8) begin @(posedge clk); n++; end
    @(negedge clk);
    start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd3;
    @(posedge clk); n++;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, n);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd42);
    extra = 0;
    repeat (60) begin @(posedge clk); #1; if (done) extra++; end
    check("ign_extra_done", 64'(extra), 64'd0);
    check("ign_busy_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation
    launch(2'b01, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_check("divu_after_rst", 2'b11, 32'd100, 32'd3, 32'd1, 32'd33);

    // MTHI/MTLO writes
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h12345678;
    @(posedge clk); #1;
    check("mthi", 64'(hi), 64'h12345678);
    check("mthi_lo_kept", 64'(lo), 64'd33);
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("mt_both_hi", 64'(hi), 64'hA5A5A5A5);
    check("mt_both_lo", 64'(lo), 64'hA5A5A5A5);
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b1; wr_data = 32'hCAFEBABE;
    start = 1'b1; op = 2'b01; operand_a = 32'd2; operand_b = 32'd3;
    @(posedge clk); #1;
    check("mtlo_vs_start", 64'(lo), 64'hA5A5A5A5);
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    n = 0;
    repeat (3) begin @(posedge clk); n++; end
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hDEADBEEF;
    @(posedge clk); n++; #1;
    check("mthi_busy", 64'(hi), 64'hA5A5A5A5);
    @(negedge clk);
    wr_hi = 1'b0;
    wait_done(n, n);
    check("mul_after_wr_hi", 64'(hi), 64'd0);
    check("mul_after_wr_lo", 64'(lo), 64'd6);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      model(rop, ra, rb, eh, el);
      run_check($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, eh, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
